axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_wr_arbiter.sv | 119 +++++++++++
 tb/tb_axi_wr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: two-master AXI write arbiter with in-order W and B routing
module axi_wr_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [89:0] m_awinfo,
    input  logic [1:0]  m_awvalid,
    output logic [1:0]  m_awready,
    input  logic [73:0] m_winfo,
    input  logic [1:0]  m_wvalid,
    output logic [1:0]  m_wready,
    output logic [3:0]  m_bid,
    output logic [1:0]  m_bresp,
    output logic [1:0]  m_bvalid,
    input  logic [1:0]  m_bready,
    output logic [44:0] s_awinfo,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [3:0]  WID,
    output logic [36:0] s_winfo,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic        err_unexp_b
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {ARB, ISSUE} state_t;
    state_t state_q, state_d;
    logic rr_q, rr_d;
    logic [44:0] aw_q, aw_d;
    logic err_q, err_d;
    logic g, grant;
    logic [44:0] aw_sel;
    logic [4:0] w_mem [FIFO_DEPTH];
    logic b_mem [FIFO_DEPTH];
    logic [PW-1:0] w_wr_q, w_rd_q, b_wr_q, b_rd_q;
    logic [CW-1:0] w_cnt_q, b_cnt_q;
    logic w_full, w_empty, b_full, b_empty, w_act, b_act, h, b, w_pop, b_pop;
    assign w_full  = w_cnt_q == CW'(FIFO_DEPTH);
    assign b_full  = b_cnt_q == CW'(FIFO_DEPTH);
    assign w_empty = w_cnt_q == '0;
    assign b_empty = b_cnt_q == '0;
    assign aw_sel  = g ? m_awinfo[89:45] : m_awinfo[44:0];
    // AW arbitration: round-robin grant in ARB, hold the registered request in ISSUE
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        aw_d    = aw_q;
        err_d   = err_q | (BVALID & b_empty);
        grant   = 1'b0;
        g       = m_awvalid[rr_q] ? rr_q : ~rr_q;
        if (state_q == ARB) begin
            if (ARESETn && |m_awvalid && !w_full && !b_full) begin
                grant   = 1'b1;
                aw_d    = aw_sel;
                rr_d    = ~g;
                state_d = ISSUE;
            end
        end else if (AWREADY) begin
            state_d = ARB;
        end
    end
    assign m_awready   = {grant & g, grant & ~g};
    assign AWVALID     = ARESETn & (state_q == ISSUE);
    assign s_awinfo    = aw_q;
    assign err_unexp_b = err_q;
    assign h       = w_mem[w_rd_q][4];
    assign WID     = w_mem[w_rd_q][3:0];
    assign s_winfo = h ? m_winfo[73:37] : m_winfo[36:0];
    assign w_act   = ARESETn & ~w_empty;
    assign WVALID  = w_act & m_wvalid[h];
    assign m_wready = {w_act & WREADY & h, w_act & WREADY & ~h};
    assign w_pop   = WVALID & WREADY & s_winfo[0];
    assign b       = b_mem[b_rd_q];
    assign b_act   = ARESETn & ~b_empty;
    assign m_bvalid = {b_act & BVALID & b, b_act & BVALID & ~b};
    assign BREADY  = b_act & m_bready[b];
    assign b_pop   = BVALID & BREADY;
    assign m_bid   = BID;
    assign m_bresp = BRESP;
    // State, round-robin pointer, error flag and order-FIFO pointers/counts
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ARB;
            rr_q    <= 1'b0;
            aw_q    <= '0;
            err_q   <= 1'b0;
            w_wr_q  <= '0;
            w_rd_q  <= '0;
            b_wr_q  <= '0;
            b_rd_q  <= '0;
            w_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            aw_q    <= aw_d;
            err_q   <= err_d;
            w_wr_q  <= w_wr_q + PW'(grant);
            w_rd_q  <= w_rd_q + PW'(w_pop);
            b_wr_q  <= b_wr_q + PW'(grant);
            b_rd_q  <= b_rd_q + PW'(b_pop);
            w_cnt_q <= w_cnt_q + CW'(grant) - CW'(w_pop);
            b_cnt_q <= b_cnt_q + CW'(grant) - CW'(b_pop);
        end
    end
    // Order FIFO storage: {master, AWID} for W routing, master for B routing
    always_ff @(posedge ACLK) begin
        if (grant) begin
            w_mem[w_wr_q] <= {g, aw_sel[44:41]};
            b_mem[b_wr_q] <= g;
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: vector table plus scoreboarded sequences for axi_wr_arbiter
module tb_axi_wr_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [89:0] m_awinfo;
    logic [1:0]  m_awvalid, m_awready;
    logic [73:0] m_winfo;
    logic [1:0]  m_wvalid, m_wready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp, m_bvalid, m_bready;
    logic [44:0] s_awinfo;
    logic        AWVALID, AWREADY;
    logic [3:0]  WID;
    logic [36:0] s_winfo;
    logic        WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY, err_unexp_b;

    axi_wr_arbiter #(.FIFO_DEPTH(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_awinfo(m_awinfo), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_winfo(m_winfo), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awinfo(s_awinfo), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .s_winfo(s_winfo), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .err_unexp_b(err_unexp_b)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  awv;
        logic        awr;
        logic [1:0]  e_awready;
        logic        e_awvalid;
        logic [44:0] e_aw;
    } vec_t;
    typedef struct {
        logic       m;
        logic [1:0] r;
    } bexp_t;

    vec_t        tv [11];
    logic [4:0]  wq [$];
    bexp_t       bq [$];
    int          total = 0;
    int          bad = 0;
    logic [44:0] a0, a1;

    function automatic logic [44:0] awp(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        return {id, addr, len, 3'd2, 2'd1};
    endfunction

    function automatic logic [36:0] wpk(input logic [31:0] d, input logic last);
        return {d, 4'hf, last};
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic clear_inputs;
        m_awvalid = 2'b00;
        AWREADY   = 1'b0;
        m_wvalid  = 2'b00;
        WREADY    = 1'b0;
        m_bready  = 2'b00;
        BVALID    = 1'b0;
        BID       = 4'h0;
        BRESP     = 2'b00;
    endtask

    task automatic rst_cycle;
        ARESETn = 1'b0;
        clear_inputs();
        wq.delete();
        bq.delete();
        step();
        ARESETn = 1'b1;
    endtask

    task automatic chk_b;
        bexp_t e;
        total++;
        if (bq.size() == 0 || m_bvalid == 2'b00) begin
            bad++;
            $display("FAIL b_out: got bvalid %0h with %0d expected pending", m_bvalid, bq.size());
        end else begin
            e = bq.pop_front();
            chk("b_master", {62'd0, m_bvalid}, e.m ? 64'd2 : 64'd1);
            chk("b_resp", {62'd0, m_bresp}, {62'd0, e.r});
        end
    endtask

    task automatic chk_w(input logic [31:0] d0, input logic [31:0] d1);
        logic [4:0] e;
        total++;
        if (wq.size() == 0 || !WVALID) begin
            bad++;
            $display("FAIL w_out: got wvalid %0b with %0d expected pending", WVALID, wq.size());
        end else begin
            e = wq.pop_front();
            chk("w_id", {60'd0, WID}, {60'd0, e[3:0]});
            chk("w_ready", {62'd0, m_wready}, e[4] ? 64'd2 : 64'd1);
            chk("w_data", {27'd0, s_winfo}, {27'd0, e[4] ? wpk(d1, 1'b1) : wpk(d0, 1'b1)});
        end
    endtask

    initial begin
        a0 = awp(4'h1, 32'h1000, 4'h0);
        a1 = awp(4'h2, 32'h2000, 4'h0);
        tv[0]  = '{2'b11, 1'b0, 2'b01, 1'b0, 45'd0};
        tv[1]  = '{2'b10, 1'b0, 2'b00, 1'b1, a0};
        tv[2]  = '{2'b10, 1'b1, 2'b00, 1'b1, a0};
        tv[3]  = '{2'b10, 1'b0, 2'b10, 1'b0, a0};
        tv[4]  = '{2'b00, 1'b1, 2'b00, 1'b1, a1};
        tv[5]  = '{2'b00, 1'b0, 2'b00, 1'b0, a1};
        tv[6]  = '{2'b11, 1'b0, 2'b01, 1'b0, a1};
        tv[7]  = '{2'b10, 1'b1, 2'b00, 1'b1, a0};
        tv[8]  = '{2'b10, 1'b0, 2'b10, 1'b0, a0};
        tv[9]  = '{2'b00, 1'b1, 2'b00, 1'b1, a1};
        tv[10] = '{2'b00, 1'b0, 2'b00, 1'b0, a1};

        // reset with every input asserted: no handshake may leak out
        ARESETn   = 1'b0;
        m_awinfo  = {a1, a0};
        m_winfo   = {wpk(32'hB1B1_0000, 1'b1), wpk(32'hA0A0_0000, 1'b1)};
        m_awvalid = 2'b11;
        AWREADY   = 1'b1;
        m_wvalid  = 2'b11;
        WREADY    = 1'b1;
        m_bready  = 2'b11;
        BVALID    = 1'b1;
        BID       = 4'h0;
        BRESP     = 2'b00;
        settle();
        chk("rst_awready", {62'd0, m_awready}, 64'd0);
        chk("rst_awvalid", {63'd0, AWVALID}, 64'd0);
        chk("rst_wvalid", {63'd0, WVALID}, 64'd0);
        chk("rst_wready", {62'd0, m_wready}, 64'd0);
        chk("rst_bready", {63'd0, BREADY}, 64'd0);
        chk("rst_bvalid", {62'd0, m_bvalid}, 64'd0);
        step();
        settle();
        chk("rst_awinfo", {19'd0, s_awinfo}, 64'd0);
        chk("rst_err", {63'd0, err_unexp_b}, 64'd0);
        step();
        ARESETn = 1'b1;
        clear_inputs();

        // AW arbitration table, starting in the first cycle after reset
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            m_awvalid = tv[i].awv;
            AWREADY   = tv[i].awr;
            settle();
            chk($sformatf("tv%0d_awready", i), {62'd0, m_awready}, {62'd0, tv[i].e_awready});
            chk($sformatf("tv%0d_awvalid", i), {63'd0, AWVALID}, {63'd0, tv[i].e_awvalid});
            chk($sformatf("tv%0d_awinfo", i), {19'd0, s_awinfo}, {19'd0, tv[i].e_aw});
        end
        wq.push_back(5'h01); wq.push_back(5'h12); wq.push_back(5'h01); wq.push_back(5'h12);
        bq.push_back('{1'b0, 2'b00}); bq.push_back('{1'b1, 2'b00});
        bq.push_back('{1'b0, 2'b00}); bq.push_back('{1'b1, 2'b00});

        // drain W order FIFO with single-beat bursts from both masters
        for (int k = 0; k < 4; k++) begin
            step();
            m_awvalid = 2'b00;
            AWREADY   = 1'b0;
            m_winfo   = {wpk(32'hB1B1_0000 + k, 1'b1), wpk(32'hA0A0_0000 + k, 1'b1)};
            m_wvalid  = 2'b11;
            WREADY    = 1'b1;
            settle();
            chk_w(32'hA0A0_0000 + k, 32'hB1B1_0000 + k);
        end
        step();
        settle();
        chk("w_empty_valid", {63'd0, WVALID}, 64'd0);
        chk("w_empty_ready", {62'd0, m_wready}, 64'd0);

        // B order FIFO full: no grant until a B handshake, not even in the pop cycle
        m_wvalid = 2'b00;
        WREADY   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            m_awvalid = 2'b01;
            settle();
            chk($sformatf("full_block%0d", k), {62'd0, m_awready}, 64'd0);
        end
        step();
        BVALID   = 1'b1;
        BID      = 4'h1;
        BRESP    = 2'b00;
        m_bready = 2'b11;
        settle();
        chk_b();
        chk("full_bready", {63'd0, BREADY}, 64'd1);
        chk("full_pop_nogrant", {62'd0, m_awready}, 64'd0);
        step();
        BVALID = 1'b0;
        settle();
        chk("full_freed_grant", {62'd0, m_awready}, 64'd1);
        step();
        m_awvalid = 2'b00;
        settle();
        chk("full_freed_issue", {63'd0, AWVALID}, 64'd1);
        rst_cycle();

        // B responses return in AW order: M1 then M0
        m_awinfo  = {awp(4'h2, 32'h2000, 4'h0), awp(4'h1, 32'h1000, 4'h0)};
        m_awvalid = 2'b10;
        settle();
        chk("bo_grant_m1", {62'd0, m_awready}, 64'd2);
        bq.push_back('{1'b1, 2'b00});
        step();
        m_awvalid = 2'b00;
        AWREADY   = 1'b1;
        settle();
        chk("bo_issue_m1", {63'd0, AWVALID}, 64'd1);
        step();
        AWREADY   = 1'b0;
        m_awvalid = 2'b01;
        settle();
        chk("bo_grant_m0", {62'd0, m_awready}, 64'd1);
        bq.push_back('{1'b0, 2'b10});
        step();
        m_awvalid = 2'b00;
        AWREADY   = 1'b1;
        step();
        AWREADY  = 1'b0;
        BVALID   = 1'b1;
        BRESP    = 2'b00;
        BID      = 4'h2;
        m_bready = 2'b11;
        settle();
        chk_b();
        chk("bo_bid1", {60'd0, m_bid}, 64'd2);
        chk("bo_bready1", {63'd0, BREADY}, 64'd1);
        step();
        BRESP = 2'b10;
        BID   = 4'h1;
        settle();
        chk_b();
        chk("bo_bid2", {60'd0, m_bid}, 64'd1);
        step();
        BVALID = 1'b0;
        settle();
        chk("bo_idle", {62'd0, m_bvalid}, 64'd0);

        // unexpected B response with nothing outstanding
        step();
        BVALID = 1'b1;
        settle();
        chk("unexp_bready", {63'd0, BREADY}, 64'd0);
        chk("unexp_bvalid", {62'd0, m_bvalid}, 64'd0);
        chk("unexp_err_pre", {63'd0, err_unexp_b}, 64'd0);
        step();
        BVALID = 1'b0;
        settle();
        chk("unexp_err_set", {63'd0, err_unexp_b}, 64'd1);
        step();
        step();
        settle();
        chk("unexp_err_hold", {63'd0, err_unexp_b}, 64'd1);
        rst_cycle();
        settle();
        chk("unexp_err_clr", {63'd0, err_unexp_b}, 64'd0);

        // 4-beat burst with AWREADY held low; W flows during ISSUE
        a0 = awp(4'h1, 32'h3000, 4'h3);
        m_awinfo  = {a1, a0};
        m_awvalid = 2'b01;
        settle();
        chk("bu_grant", {62'd0, m_awready}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            m_awvalid = 2'b00;
            m_winfo   = {wpk(32'h0, 1'b0), wpk(32'hC0DE_0000 + k, k == 3)};
            m_wvalid  = 2'b01;
            WREADY    = 1'b1;
            settle();
            chk($sformatf("bu_awvalid%0d", k), {63'd0, AWVALID}, 64'd1);
            chk($sformatf("bu_awinfo%0d", k), {19'd0, s_awinfo}, {19'd0, a0});
            if (k < 4) begin
                chk($sformatf("bu_wvalid%0d", k), {63'd0, WVALID}, 64'd1);
                chk($sformatf("bu_wid%0d", k), {60'd0, WID}, 64'd1);
                chk($sformatf("bu_wready%0d", k), {62'd0, m_wready}, 64'd1);
                chk($sformatf("bu_wdata%0d", k), {27'd0, s_winfo}, {27'd0, wpk(32'hC0DE_0000 + k, k == 3)});
            end else begin
                chk("bu_popped_wvalid", {63'd0, WVALID}, 64'd0);
                chk("bu_popped_wready", {62'd0, m_wready}, 64'd0);
            end
        end
        step();
        m_wvalid = 2'b00;
        WREADY   = 1'b0;
        AWREADY  = 1'b1;
        settle();
        chk("bu_issue_end", {63'd0, AWVALID}, 64'd1);
        step();
        AWREADY = 1'b0;
        settle();
        chk("bu_back_arb", {63'd0, AWVALID}, 64'd0);

        // reset during the 2nd W beat of a burst
        a0 = awp(4'h3, 32'h4000, 4'h3);
        m_awinfo  = {a1, a0};
        m_awvalid = 2'b01;
        settle();
        chk("mr_grant", {62'd0, m_awready}, 64'd1);
        step();
        m_awvalid = 2'b00;
        AWREADY   = 1'b1;
        m_winfo   = {wpk(32'h0, 1'b0), wpk(32'hD000_0001, 1'b0)};
        m_wvalid  = 2'b01;
        WREADY    = 1'b1;
        settle();
        chk("mr_beat1_wready", {62'd0, m_wready}, 64'd1);
        chk("mr_beat1_wid", {60'd0, WID}, 64'd3);
        step();
        AWREADY   = 1'b0;
        m_winfo   = {wpk(32'h0, 1'b0), wpk(32'hD000_0002, 1'b0)};
        ARESETn   = 1'b0;
        m_awvalid = 2'b11;
        BVALID    = 1'b1;
        m_bready  = 2'b11;
        settle();
        chk("mr_in_wvalid", {63'd0, WVALID}, 64'd0);
        chk("mr_in_wready", {62'd0, m_wready}, 64'd0);
        chk("mr_in_awready", {62'd0, m_awready}, 64'd0);
        chk("mr_in_bready", {63'd0, BREADY}, 64'd0);
        step();
        ARESETn   = 1'b1;
        m_awvalid = 2'b00;
        BVALID    = 1'b0;
        settle();
        chk("mr_post_wvalid", {63'd0, WVALID}, 64'd0);
        chk("mr_post_wready", {62'd0, m_wready}, 64'd0);
        chk("mr_post_awvalid", {63'd0, AWVALID}, 64'd0);
        chk("mr_post_awinfo", {19'd0, s_awinfo}, 64'd0);
        chk("mr_post_err", {63'd0, err_unexp_b}, 64'd0);
        step();
        m_wvalid  = 2'b00;
        WREADY    = 1'b0;
        m_awvalid = 2'b11;
        settle();
        chk("mr_regrant", {62'd0, m_awready}, 64'd1);
        step();
        m_awvalid = 2'b00;
        settle();
        chk("mr_reissue", {63'd0, AWVALID}, 64'd1);
        chk("mr_reinfo", {19'd0, s_awinfo}, {19'd0, a0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
